// File: rtl/multiplicador_secuencial_param.sv
// Sequential shift-add multiplier: WIDTH iterations per product, valid/ready start, one-cycle done pulse.
// Define MULT_SIGNED_EN to honour signed_mode (two's-complement operands and product).
module multiplicador_secuencial_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  output logic               ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [PW-1:0]    PW_ZERO  = {PW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic             neg_r;
  logic             done_r;
  logic [PW-1:0]    product_r;
  logic [PW-1:0]    acc_next_s;
  logic [PW-1:0]    result_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             neg_in_s;
  logic             accept_s;
  logic             last_s;

  // Reset synchroniser: assertion reaches the core immediately, release is aligned to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

`ifdef MULT_SIGNED_EN
  localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);
  localparam logic [PW-1:0]    PW_ONE = PW'(1);

  function automatic logic [WIDTH-1:0] abs_operand(input logic [WIDTH-1:0] x, input logic is_signed);
    if (is_signed && x[WIDTH-1]) begin
      abs_operand = ~x + W_ONE;
    end else begin
      abs_operand = x;
    end
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] x);
    negate = ~x + PW_ONE;
  endfunction

  // Magnitudes feed the unsigned core; the sign is reapplied when the result is written.
  always_comb begin
    mag_a_s  = abs_operand(a, signed_mode);
    mag_b_s  = abs_operand(b, signed_mode);
    neg_in_s = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    if (neg_r) begin
      result_s = negate(acc_next_s);
    end else begin
      result_s = acc_next_s;
    end
  end
`else
  logic unused_signed_s;

  // Unsigned-only build: operands pass straight through and the sign flag stays 0.
  always_comb begin
    mag_a_s         = a;
    mag_b_s         = b;
    neg_in_s        = 1'b0;
    result_s        = acc_next_s;
    unused_signed_s = signed_mode ^ neg_r;
  end
`endif

  assign accept_s = valid && (state_r == ST_IDLE);
  assign last_s   = (cnt_r == CNT_LAST);

  // Conditional add of the shifted multiplicand for the current multiplier bit.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; abort only matters while iterating.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid) begin
          state_next_s = ST_MULT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MULT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath, iteration counter and registered result/done.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= PW_ZERO;
      mcand_r   <= PW_ZERO;
      mplier_r  <= {WIDTH{1'b0}};
      neg_r     <= 1'b0;
      done_r    <= 1'b0;
      product_r <= PW_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_r     <= CNT_ZERO;
            acc_r     <= PW_ZERO;
            mcand_r   <= {{WIDTH{1'b0}}, mag_a_s};
            mplier_r  <= mag_b_s;
            neg_r     <= neg_in_s;
            product_r <= PW_ZERO;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_MULT: begin
          if (abort) begin
            product_r <= PW_ZERO;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            // Counter parks on the last index instead of wrapping.
            if (last_s) begin
              product_r <= result_s;
              done_r    <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = (state_r == ST_IDLE);
  assign busy    = (state_r == ST_MULT) || (state_r == ST_DONE);
  assign done    = done_r;
  assign product = product_r;

endmodule
